// File: rtl/cpu_pkg.sv
// Shared CPU types: register/word widths and the write-back source enum.
// Also holds a small helper that flips the round-robin pointer.
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

    function automatic wb_src_e wb_flip(input wb_src_e s);
        return (s == WB_ALU) ? WB_MEM : WB_ALU;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter (ALU vs memory write-back).
// Ports: clock, reset, req_alu/req_mem in; gnt_alu/gnt_mem out (one-hot or zero).
module rr_arbiter2
    import cpu_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    // prio names the requester that wins the next conflict.
    wb_src_e prio;
    logic    conflict;

    always_comb begin
        conflict = req_alu & req_mem;
        gnt_alu  = req_alu & (~req_mem | (prio == WB_ALU));
        gnt_mem  = req_mem & (~req_alu | (prio == WB_MEM));
    end

    // Only a conflict moves the pointer; single requests leave it alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio <= WB_ALU;
        end else if (conflict) begin
            prio <= wb_flip(prio);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter + scoreboard for the 8x16 register file write port.
// Ports: ALU/MEM valid-ready requests in, sb_set marks pending, rf_* registered
// write outputs, busy_mask pending bits, conflict_cnt saturating conflict count.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    input  logic                sb_set,
    input  logic [ADDR_W-1:0]   sb_set_addr,
    output logic                rf_write,
    output logic [ADDR_W-1:0]   rf_rd_addr,
    output logic [DATA_W-1:0]   rf_data,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [7:0]          conflict_cnt
);

    import cpu_pkg::*;

    logic              accept;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic [NUM_REGS-1:0] busy_nxt;

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req_alu (alu_valid),
        .req_mem (mem_valid),
        .gnt_alu (alu_ready),
        .gnt_mem (mem_ready)
    );

    always_comb begin
        accept   = alu_ready | mem_ready;
        sel_rd   = '0;
        sel_data = '0;
        unique case (1'b1)
            alu_ready: begin
                sel_rd   = alu_rd;
                sel_data = alu_data;
            end
            mem_ready: begin
                sel_rd   = mem_rd;
                sel_data = mem_data;
            end
            default: ;
        endcase
    end

    // The write held in rf_* commits at this edge, so it clears its bit now;
    // a same-edge set is applied afterwards so a newer producer stays pending.
    always_comb begin
        busy_nxt = busy_mask;
        if (rf_write) begin
            busy_nxt[rf_rd_addr] = 1'b0;
        end
        if (sb_set) begin
            busy_nxt[sb_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_write   <= 1'b0;
            rf_rd_addr <= '0;
            rf_data    <= '0;
        end else begin
            rf_write <= accept;
            if (accept) begin
                rf_rd_addr <= sel_rd;
                rf_data    <= sel_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= busy_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict_cnt <= 8'd0;
        end else if (alu_valid && mem_valid && conflict_cnt != 8'hFF) begin
            conflict_cnt <= conflict_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus reset and
// saturation sequences, with a small register-file model on the rf_* outputs.
module tb_regfile_wb_arbiter;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic [2:0]  alu_rd;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [2:0]  mem_rd;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        sb_set;
    logic [2:0]  sb_set_addr;
    logic        rf_write;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_data;
    logic [7:0]  busy_mask;
    logic [7:0]  conflict_cnt;

    int n_cmp;
    int n_bad;

    logic [15:0] rf_model [8];

    regfile_wb_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .sb_set       (sb_set),
        .sb_set_addr  (sb_set_addr),
        .rf_write     (rf_write),
        .rf_rd_addr   (rf_rd_addr),
        .rf_data      (rf_data),
        .busy_mask    (busy_mask),
        .conflict_cnt (conflict_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (rf_write) rf_model[rf_rd_addr] <= rf_data;
    end

    typedef struct {
        logic        av;
        logic [2:0]  ar;
        logic [15:0] ad;
        logic        mv;
        logic [2:0]  mr;
        logic [15:0] md;
        logic        ss;
        logic [2:0]  sa;
        logic        ear;
        logic        emr;
        logic        ew;
        logic [2:0]  ea;
        logic [15:0] ed;
        logic [7:0]  eb;
        logic [7:0]  ec;
    } vec_t;

    vec_t vt [19];

    function automatic vec_t mk(
        input logic av, input logic [2:0] ar, input logic [15:0] ad,
        input logic mv, input logic [2:0] mr, input logic [15:0] md,
        input logic ss, input logic [2:0] sa,
        input logic ear, input logic emr,
        input logic ew, input logic [2:0] ea, input logic [15:0] ed,
        input logic [7:0] eb, input logic [7:0] ec);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad;
        v.mv = mv; v.mr = mr; v.md = md;
        v.ss = ss; v.sa = sa;
        v.ear = ear; v.emr = emr;
        v.ew = ew; v.ea = ea; v.ed = ed;
        v.eb = eb; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        alu_valid   = v.av;
        alu_rd      = v.ar;
        alu_data    = v.ad;
        mem_valid   = v.mv;
        mem_rd      = v.mr;
        mem_data    = v.md;
        sb_set      = v.ss;
        sb_set_addr = v.sa;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int r = 0; r < 8; r++) rf_model[r] = 16'h0;
        reset = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        sb_set = 0; sb_set_addr = 0;

        //      av ar  ad        mv mr md        ss sa ear emr ew ea ed        eb     ec
        vt[0]  = mk(1,0,16'h0001, 0,0,16'h0000, 0,0, 1,0, 1,0,16'h0001, 8'h00, 8'd0);
        vt[1]  = mk(0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, 0,0,16'h0000, 8'h00, 8'd0);
        vt[2]  = mk(0,0,16'h0000, 1,5,16'h00FF, 0,0, 0,1, 1,5,16'h00FF, 8'h00, 8'd0);
        vt[3]  = mk(1,1,16'h00AB, 1,7,16'h1234, 0,0, 1,0, 1,1,16'h00AB, 8'h00, 8'd1);
        vt[4]  = mk(1,1,16'h00AB, 1,7,16'h1234, 0,0, 0,1, 1,7,16'h1234, 8'h00, 8'd2);
        vt[5]  = mk(1,1,16'h00AB, 1,7,16'h1234, 0,0, 1,0, 1,1,16'h00AB, 8'h00, 8'd3);
        vt[6]  = mk(1,1,16'h00AB, 1,7,16'h1234, 0,0, 0,1, 1,7,16'h1234, 8'h00, 8'd4);
        vt[7]  = mk(0,0,16'h0000, 0,0,16'h0000, 1,7, 0,0, 0,0,16'h0000, 8'h80, 8'd4);
        vt[8]  = mk(0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, 0,0,16'h0000, 8'h80, 8'd4);
        vt[9]  = mk(0,0,16'h0000, 1,7,16'h5555, 0,0, 0,1, 1,7,16'h5555, 8'h80, 8'd4);
        vt[10] = mk(0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, 0,0,16'h0000, 8'h00, 8'd4);
        vt[11] = mk(1,3,16'h0333, 0,0,16'h0000, 1,3, 1,0, 1,3,16'h0333, 8'h08, 8'd4);
        vt[12] = mk(0,0,16'h0000, 0,0,16'h0000, 1,3, 0,0, 0,0,16'h0000, 8'h08, 8'd4);
        vt[13] = mk(1,3,16'h0444, 0,0,16'h0000, 0,0, 1,0, 1,3,16'h0444, 8'h08, 8'd4);
        vt[14] = mk(0,0,16'h0000, 0,0,16'h0000, 1,4, 0,0, 0,0,16'h0000, 8'h10, 8'd4);
        vt[15] = mk(0,0,16'h0000, 1,4,16'h0ABC, 0,0, 0,1, 1,4,16'h0ABC, 8'h10, 8'd4);
        vt[16] = mk(0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, 0,0,16'h0000, 8'h00, 8'd4);
        vt[17] = mk(1,6,16'h0666, 0,0,16'h0000, 0,0, 1,0, 1,6,16'h0666, 8'h00, 8'd4);
        vt[18] = mk(0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0, 0,0,16'h0000, 8'h00, 8'd4);

        #1;
        chk("rst rf_write", rf_write, 0);
        chk("rst rf_rd_addr", rf_rd_addr, 0);
        chk("rst rf_data", rf_data, 0);
        chk("rst busy_mask", busy_mask, 0);
        chk("rst conflict_cnt", conflict_cnt, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            drive(vt[i]);
            #1;
            chk($sformatf("v%0d alu_ready", i), alu_ready, vt[i].ear);
            chk($sformatf("v%0d mem_ready", i), mem_ready, vt[i].emr);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d rf_write", i), rf_write, vt[i].ew);
            if (vt[i].ew) begin
                chk($sformatf("v%0d rf_rd_addr", i), rf_rd_addr, vt[i].ea);
                chk($sformatf("v%0d rf_data", i), rf_data, vt[i].ed);
            end
            chk($sformatf("v%0d busy_mask", i), busy_mask, vt[i].eb);
            chk($sformatf("v%0d conflict_cnt", i), conflict_cnt, vt[i].ec);
        end

        chk("rf R0", rf_model[0], 16'h0001);
        chk("rf R1", rf_model[1], 16'h00AB);
        chk("rf R3", rf_model[3], 16'h0444);
        chk("rf R4", rf_model[4], 16'h0ABC);
        chk("rf R5", rf_model[5], 16'h00FF);
        chk("rf R6", rf_model[6], 16'h0666);
        chk("rf R7", rf_model[7], 16'h5555);

        // Reset right after an accepted ALU write: the write must be dropped
        // and the pointer (now favouring MEM) must return to ALU.
        @(negedge clock);
        alu_valid = 1; alu_rd = 2; alu_data = 16'hBEEF;
        mem_valid = 1; mem_rd = 5; mem_data = 16'hDEAD;
        sb_set = 1; sb_set_addr = 2;
        #1;
        chk("mid alu_ready", alu_ready, 1);
        @(posedge clock);
        #2;
        chk("mid pre rf_write", rf_write, 1);
        reset = 1'b1;
        #1;
        chk("mid rf_write", rf_write, 0);
        chk("mid busy_mask", busy_mask, 0);
        chk("mid conflict_cnt", conflict_cnt, 0);
        alu_valid = 0; mem_valid = 0; sb_set = 0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("mid R2 kept", rf_model[2], 16'h0000);
        chk("mid R5 kept", rf_model[5], 16'h00FF);

        // Hold both requesters for 300 cycles: strict alternation from ALU.
        @(negedge clock);
        alu_valid = 1; alu_rd = 1; alu_data = 16'h00AB;
        mem_valid = 1; mem_rd = 7; mem_data = 16'h1234;
        for (int k = 0; k < 300; k++) begin
            if (k != 0) @(negedge clock);
            #1;
            chk($sformatf("sat%0d alu_ready", k), alu_ready, (k % 2) == 0);
            chk($sformatf("sat%0d mem_ready", k), mem_ready, (k % 2) == 1);
            @(posedge clock);
        end
        #1;
        chk("sat conflict_cnt", conflict_cnt, 8'd255);
        chk("sat rf_write", rf_write, 1);
        chk("sat rf_rd_addr", rf_rd_addr, 7);
        @(negedge clock);
        alu_valid = 0; mem_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back arbiter and scoreboard for the 8-entry, 16-bit register_file. It shares the file's single write port between two requesters, the ALU result path and the memory-load path, using round-robin arbitration with a valid/ready handshake. It drives the register file's write, rd_addr and data inputs from registered outputs. It also keeps a per-register pending (busy) mask so issue logic can stall on read-after-write hazards.

Parameters:
DATA_W, 16, width of write-back data
ADDR_W, 3, register address width
NUM_REGS, 8, number of registers; must equal 2**ADDR_W

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU write-back request
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU request accepted this cycle
mem_valid  in  1  memory-load write-back request
mem_rd  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
mem_ready  out  1  load request accepted this cycle
sb_set  in  1  issue logic marks a register pending
sb_set_addr  in  ADDR_W  register to mark pending
rf_write  out  1  to register_file write
rf_rd_addr  out  ADDR_W  to register_file rd_addr
rf_data  out  DATA_W  to register_file data
busy_mask  out  NUM_REGS  bit i = register i has a write-back outstanding
conflict_cnt  out  8  saturating count of cycles where both requesters were valid

Behaviour:
- Reset values: rf_write=0, rf_rd_addr=0, rf_data=0, busy_mask=0, conflict_cnt=0. The round-robin pointer is reset so that the ALU wins the first conflict.
- Handshake:
  - A transfer occurs on a rising edge when valid && ready.
  - A requester holds valid, rd and data stable until it is accepted.
  - ready is combinational from the valid inputs and the round-robin pointer. ready never depends on ready.
  - Each cycle, at most one requester sees ready=1.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not granted at the last conflict, then flip the pointer.
  - The pointer updates only on conflict cycles.
  - Neither valid: no grant, and the pointer holds.
- Output register and latency:
  - A request accepted at edge N drives rf_write=1 with its rd/data during cycle N..N+1.
  - The register file commits it at edge N+1.
  - rf_write deasserts the following cycle unless another request is accepted.
  - Back-to-back acceptance sustains one write per cycle, with zero bubbles.
- Scoreboard:
  - sb_set at edge E sets busy_mask[sb_set_addr].
  - The bit clears at the same edge the register file commits a write to that address (rf_write=1, rf_rd_addr matches).
  - Set and clear of the same register at the same edge: set wins and the bit stays 1 (a newer producer is pending).
  - Set and clear of different registers at the same edge: both take effect.
  - A write-back to a non-busy register is legal and leaves the bit at 0.
- conflict_cnt increments on every cycle where alu_valid && mem_valid, and saturates at 255.
- Register 0 is an ordinary writable register, with no hardwired zero.
- Reset mid-operation: a write held in the output register is dropped (rf_write=0 immediately), busy_mask and the pointer are cleared, and no partial state survives.
- No combinational path from any input to rf_write, rf_rd_addr or rf_data.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and ADDR_W constants
  - a reg_addr_t typedef (logic [ADDR_W-1:0])
  - a word_t typedef (logic [DATA_W-1:0])
  - a wb_src_e enum {WB_ALU, WB_MEM} used as the round-robin pointer type
- One sub-module, rr_arbiter2: a two-requester round-robin arbiter with valid inputs, grant outputs and pointer state.
- The scoreboard and output register stay inline.

Test Plan:
- ALU only:
  - Stimulus: alu_valid=1, alu_rd=0, alu_data=16'h0001 for one cycle.
  - Response: alu_ready=1. Next cycle rf_write=1, rf_rd_addr=0, rf_data=1. A register_file read of R0 returns 1 afterwards.
- Conflict round-robin:
  - Stimulus: both valid for 4 cycles, with alu_rd=1/data=16'h00AB and mem_rd=7/data=16'h1234, each requester deasserting valid after acceptance and reasserting the next cycle.
  - Response: grant order ALU, MEM, ALU, MEM. conflict_cnt=4.
- Scoreboard:
  - Stimulus: sb_set addr 7, then a mem write-back to 7.
  - Response: busy_mask=8'h80 until the commit edge, then 8'h00.
- Set/clear collision:
  - Stimulus: sb_set addr 3 in the same cycle rf_write commits to R3.
  - Response: busy_mask[3] stays 1.
- Reset mid-operation:
  - Stimulus: accept an ALU write, then assert reset asynchronously before the next edge.
  - Response: rf_write drops to 0 immediately, busy_mask=0, and R-file contents are unchanged by the dropped write.
- Saturation:
  - Stimulus: hold both valid for 300 cycles.
  - Response: conflict_cnt=255, and grants alternate throughout.
